// File: rtl/pkg_ili9341.sv
// Shared ILI9341 definitions: command codes, the 9-bit {dc, byte} word,
// decoder states, decoder reset values and the panel init command table.
package pkg_ili9341;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  // Bit 8 is D/C (0 = command, 1 = parameter/data), bits 7:0 the byte.
  typedef logic [8:0] lcd_word_t;

  typedef enum logic [1:0] {
    DEC_IDLE  = 2'd0,
    DEC_CMD   = 2'd1,
    DEC_PARAM = 2'd2,
    DEC_PIXEL = 2'd3
  } dec_state_e;

  localparam logic [7:0]  RST_MADCTL     = 8'h00;
  localparam logic [7:0]  RST_COLMOD     = 8'h66;
  localparam logic [15:0] RST_COL_START  = 16'h0000;
  localparam logic [15:0] RST_COL_END    = 16'h00EF;
  localparam logic [15:0] RST_PAGE_START = 16'h0000;
  localparam logic [15:0] RST_PAGE_END   = 16'h013F;

  localparam int INI_LEN = 47;

  // Power-up sequence sent by the LCD transmitter path.
  localparam lcd_word_t ini_commands [INI_LEN] = '{
    9'h001, 9'h028,
    9'h0EF, 9'h103, 9'h180, 9'h102,
    9'h0CF, 9'h100, 9'h1C1, 9'h130,
    9'h0ED, 9'h164, 9'h103, 9'h112, 9'h181,
    9'h0E8, 9'h185, 9'h100, 9'h178,
    9'h0C0, 9'h123,
    9'h0C1, 9'h110,
    9'h0C5, 9'h13E, 9'h128,
    9'h0C7, 9'h186,
    9'h036, 9'h148,
    9'h03A, 9'h155,
    9'h0B1, 9'h100, 9'h118,
    9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF,
    9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F,
    9'h011, 9'h029
  };

  function automatic lcd_word_t mk_word(input logic dc, input logic [7:0] b);
    return {dc, b};
  endfunction

endpackage

// File: rtl/ili9341_spi_rx.sv
// SPI mode-0 byte receiver: synchronizes SCK/CS_n/MOSI/D/C into clk,
// shifts MOSI on synchronized SCK rising edges and emits one {dc, byte}
// word per completed byte. A CS_n high discards any partial byte.
module ili9341_spi_rx
  import pkg_ili9341::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      spi_sck,
  input  logic      spi_cs_n,
  input  logic      spi_mosi,
  input  logic      spi_dc,
  output logic      word_valid,
  output lcd_word_t word_data
);

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q, dc_sync_q;
  logic                   sck_s, cs_s, mosi_s, dc_s, sck_rise;

  logic       sck_prev_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_done_q, byte_done_d;
  logic       dc_cap_q, dc_cap_d;
  logic       word_valid_q, word_valid_d;
  lcd_word_t  word_data_q, word_data_d;

  // Pin synchronizers; CS_n idles deselected out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      dc_sync_q   <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // Shift/count next state; the word is presented one cycle after the
  // byte completes so latency from the pin edge is SYNC_STAGES+2.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_done_d  = 1'b0;
    dc_cap_d     = dc_cap_q;
    word_valid_d = byte_done_q;
    word_data_d  = word_data_q;
    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d   = {shift_q[6:0], mosi_s};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_done_d = 1'b1;
        dc_cap_d    = dc_s;
      end
    end
    if (byte_done_q) begin
      word_data_d = {dc_cap_q, shift_q};
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      byte_done_q  <= 1'b0;
      dc_cap_q     <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      sck_prev_q   <= sck_s;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_done_q  <= byte_done_d;
      dc_cap_q     <= dc_cap_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_data_q;

endmodule

// File: rtl/ili9341_cmd_decoder.sv
// ILI9341 display-side command decoder. Receives 4-wire SPI writes,
// tags bytes as {dc, byte}, decodes commands/parameters into shadow
// registers and assembles RGB565 pixels during RAMWR.
// Optional init-sequence checker: define ILI9341_DEC_CHECK_EN.
// Handshake: every *_valid output is a single-cycle pulse with no
// back-pressure; the accompanying data is valid in that cycle and held
// until the next pulse of the same kind.
module ili9341_cmd_decoder
  import pkg_ili9341::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PIXEL_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sck,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  output logic               word_valid,
  output logic [8:0]         word_data,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               param_valid,
  output logic [3:0]         param_idx,
  output logic [7:0]         param_data,
  output logic               pixel_valid,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               sleep_out,
  output logic               disp_on,
  output logic [7:0]         madctl,
  output logic [7:0]         colmod,
  output logic [15:0]        col_start,
  output logic [15:0]        col_end,
  output logic [15:0]        page_start,
  output logic [15:0]        page_end
`ifdef ILI9341_DEC_CHECK_EN
  ,
  output logic               seq_err,
  output logic               seq_done
`endif
);

  logic      w_valid;
  lcd_word_t w_data;
  logic      w_dc;
  logic [7:0] w_byte;

  ili9341_spi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .spi_sck    (spi_sck),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_dc     (spi_dc),
    .word_valid (w_valid),
    .word_data  (w_data)
  );

  assign word_valid = w_valid;
  assign word_data  = w_data;
  assign w_dc       = w_data[8];
  assign w_byte     = w_data[7:0];

  dec_state_e  state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic        param_valid_q, param_valid_d;
  logic [3:0]  param_idx_q, param_idx_d;
  logic [3:0]  pcnt_q, pcnt_d;        // parameters seen since the command
  logic [7:0]  param_data_q, param_data_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [15:0] pixel_data_q, pixel_data_d;
  logic        pix_phase_q, pix_phase_d; // 1 = high byte staged
  logic [7:0]  pix_hi_q, pix_hi_d;
  logic        sleep_q, sleep_d;
  logic        disp_q, disp_d;
  logic [7:0]  madctl_q, madctl_d;
  logic [7:0]  colmod_q, colmod_d;
  logic [15:0] col_start_q, col_start_d, col_end_q, col_end_d;
  logic [15:0] page_start_q, page_start_d, page_end_q, page_end_d;
  logic [23:0] win_stage_q, win_stage_d; // SC_hi, SC_lo, EC_hi

  // Decoder FSM: next state, pulses and register updates per received word.
  always_comb begin
    state_d       = state_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    param_valid_d = 1'b0;
    param_idx_d   = param_idx_q;
    pcnt_d        = pcnt_q;
    param_data_d  = param_data_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pix_phase_d   = pix_phase_q;
    pix_hi_d      = pix_hi_q;
    sleep_d       = sleep_q;
    disp_d        = disp_q;
    madctl_d      = madctl_q;
    colmod_d      = colmod_q;
    col_start_d   = col_start_q;
    col_end_d     = col_end_q;
    page_start_d  = page_start_q;
    page_end_d    = page_end_q;
    win_stage_d   = win_stage_q;

    if (w_valid) begin
      if (!w_dc) begin
        state_d     = DEC_CMD;
        cmd_valid_d = 1'b1;
        cmd_code_d  = w_byte;
        param_idx_d = 4'd0;
        pcnt_d      = 4'd0;
        pix_phase_d = 1'b0;
        case (w_byte)
          CMD_SWRESET: begin
            sleep_d      = 1'b0;
            disp_d       = 1'b0;
            madctl_d     = RST_MADCTL;
            colmod_d     = RST_COLMOD;
            col_start_d  = RST_COL_START;
            col_end_d    = RST_COL_END;
            page_start_d = RST_PAGE_START;
            page_end_d   = RST_PAGE_END;
            win_stage_d  = '0;
          end
          CMD_SLPIN:   sleep_d = 1'b0;
          CMD_SLPOUT:  sleep_d = 1'b1;
          CMD_DISPOFF: disp_d  = 1'b0;
          CMD_DISPON:  disp_d  = 1'b1;
          CMD_RAMWR:   state_d = DEC_PIXEL;
          default: ;
        endcase
      end else begin
        case (state_q)
          DEC_CMD, DEC_PARAM: begin
            state_d       = DEC_PARAM;
            param_valid_d = 1'b1;
            param_data_d  = w_byte;
            param_idx_d   = pcnt_q;
            if (pcnt_q != 4'hF) begin
              pcnt_d = pcnt_q + 4'd1;
            end
            if (cmd_code_q == CMD_MADCTL && pcnt_q == 4'd0) begin
              madctl_d = w_byte;
            end
            if (cmd_code_q == CMD_COLMOD && pcnt_q == 4'd0) begin
              colmod_d = w_byte;
            end
            if (cmd_code_q == CMD_CASET || cmd_code_q == CMD_PASET) begin
              case (pcnt_q)
                4'd0: win_stage_d[23:16] = w_byte;
                4'd1: win_stage_d[15:8]  = w_byte;
                4'd2: win_stage_d[7:0]   = w_byte;
                4'd3: begin
                  if (cmd_code_q == CMD_CASET) begin
                    col_start_d = win_stage_q[23:8];
                    col_end_d   = {win_stage_q[7:0], w_byte};
                  end else begin
                    page_start_d = win_stage_q[23:8];
                    page_end_d   = {win_stage_q[7:0], w_byte};
                  end
                end
                default: ;
              endcase
            end
          end
          DEC_PIXEL: begin
            if (!pix_phase_q) begin
              pix_hi_d    = w_byte;
              pix_phase_d = 1'b1;
            end else begin
              pixel_valid_d = 1'b1;
              pixel_data_d  = {pix_hi_q, w_byte};
              pix_phase_d   = 1'b0;
            end
          end
          default: ; // IDLE: data with no preceding command is dropped
        endcase
      end
    end
  end

  // Decoder state and shadow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DEC_IDLE;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 8'h00;
      param_valid_q <= 1'b0;
      param_idx_q   <= 4'd0;
      pcnt_q        <= 4'd0;
      param_data_q  <= 8'h00;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= 16'h0000;
      pix_phase_q   <= 1'b0;
      pix_hi_q      <= 8'h00;
      sleep_q       <= 1'b0;
      disp_q        <= 1'b0;
      madctl_q      <= RST_MADCTL;
      colmod_q      <= RST_COLMOD;
      col_start_q   <= RST_COL_START;
      col_end_q     <= RST_COL_END;
      page_start_q  <= RST_PAGE_START;
      page_end_q    <= RST_PAGE_END;
      win_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      param_valid_q <= param_valid_d;
      param_idx_q   <= param_idx_d;
      pcnt_q        <= pcnt_d;
      param_data_q  <= param_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pix_phase_q   <= pix_phase_d;
      pix_hi_q      <= pix_hi_d;
      sleep_q       <= sleep_d;
      disp_q        <= disp_d;
      madctl_q      <= madctl_d;
      colmod_q      <= colmod_d;
      col_start_q   <= col_start_d;
      col_end_q     <= col_end_d;
      page_start_q  <= page_start_d;
      page_end_q    <= page_end_d;
      win_stage_q   <= win_stage_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign param_valid = param_valid_q;
  assign param_idx   = param_idx_q;
  assign param_data  = param_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_data_q;
  assign sleep_out   = sleep_q;
  assign disp_on     = disp_q;
  assign madctl      = madctl_q;
  assign colmod      = colmod_q;
  assign col_start   = col_start_q;
  assign col_end     = col_end_q;
  assign page_start  = page_start_q;
  assign page_end    = page_end_q;

`ifdef ILI9341_DEC_CHECK_EN
  logic [5:0] seq_idx_q, seq_idx_d;
  logic       seq_err_q, seq_err_d;
  logic       seq_done_q, seq_done_d;

  // Walk the init table word by word; stop at the first verdict.
  always_comb begin
    seq_idx_d  = seq_idx_q;
    seq_err_d  = seq_err_q;
    seq_done_d = seq_done_q;
    if (w_valid && !seq_err_q && !seq_done_q) begin
      if (w_data != ini_commands[seq_idx_q]) begin
        seq_err_d = 1'b1;
      end else if (seq_idx_q == 6'(INI_LEN - 1)) begin
        seq_done_d = 1'b1;
      end else begin
        seq_idx_d = seq_idx_q + 6'd1;
      end
    end
  end

  // Sequence checker flags; only rst clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_idx_q  <= 6'd0;
      seq_err_q  <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      seq_idx_q  <= seq_idx_d;
      seq_err_q  <= seq_err_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign seq_err  = seq_err_q;
  assign seq_done = seq_done_q;
`endif

endmodule

// File: tb/tb_ili9341_cmd_decoder.sv
// Bench for ili9341_cmd_decoder: SPI byte driver, a byte-level reference
// model of the display registers, expected-event queues checked by a
// monitor, directed scenarios plus randomized command/parameter traffic.
module tb_ili9341_cmd_decoder;
  import pkg_ili9341::*;

  localparam int SYNC = 2;
  localparam int HALF = 4; // clk cycles per SCK phase

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0, dc = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        word_valid, cmd_valid, param_valid, pixel_valid;
  logic [8:0]  word_data;
  logic [7:0]  cmd_code, param_data, madctl, colmod;
  logic [3:0]  param_idx;
  logic [15:0] pixel_data, col_start, col_end, page_start, page_end;
  logic        sleep_out, disp_on;
`ifdef ILI9341_DEC_CHECK_EN
  logic        seq_err, seq_done;
`endif

  ili9341_cmd_decoder #(.SYNC_STAGES(SYNC), .PIXEL_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sck     (sck),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_dc      (dc),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .param_valid (param_valid),
    .param_idx   (param_idx),
    .param_data  (param_data),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .sleep_out   (sleep_out),
    .disp_on     (disp_on),
    .madctl      (madctl),
    .colmod      (colmod),
    .col_start   (col_start),
    .col_end     (col_end),
    .page_start  (page_start),
    .page_end    (page_end)
`ifdef ILI9341_DEC_CHECK_EN
    ,
    .seq_err     (seq_err),
    .seq_done    (seq_done)
`endif
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  logic [8:0]  exp_word_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [11:0] exp_param_q[$];
  logic [15:0] exp_pix_q[$];

  int          m_cmd;        // last command byte, -1 when none since reset
  logic [7:0]  m_params[$];  // parameter bytes since last command
  logic [7:0]  m_pix[$];     // pending pixel bytes
  logic        m_sleep, m_disp;
  logic [7:0]  m_madctl, m_colmod;
  logic [15:0] m_cs, m_ce, m_ps, m_pe;

  task automatic model_regs_reset();
    m_sleep = 1'b0; m_disp = 1'b0;
    m_madctl = 8'h00; m_colmod = 8'h66;
    m_cs = 16'h0000; m_ce = 16'h00EF; m_ps = 16'h0000; m_pe = 16'h013F;
  endtask

  task automatic model_reset();
    m_cmd = -1;
    m_params.delete();
    m_pix.delete();
    model_regs_reset();
  endtask

  task automatic model_byte(input logic d, input logic [7:0] b);
    int idx;
    exp_word_q.push_back({d, b});
    if (!d) begin
      m_cmd = int'(b);
      m_params.delete();
      m_pix.delete();
      exp_cmd_q.push_back(b);
      case (b)
        8'h01: model_regs_reset();
        8'h10: m_sleep = 1'b0;
        8'h11: m_sleep = 1'b1;
        8'h28: m_disp = 1'b0;
        8'h29: m_disp = 1'b1;
        default: ;
      endcase
    end else if (m_cmd < 0) begin
      // data before any command carries no meaning
    end else if (m_cmd == 'h2C) begin
      m_pix.push_back(b);
      if (m_pix.size() == 2) begin
        exp_pix_q.push_back({m_pix[0], m_pix[1]});
        m_pix.delete();
      end
    end else begin
      idx = (m_params.size() > 15) ? 15 : m_params.size();
      exp_param_q.push_back({4'(idx), b});
      m_params.push_back(b);
      if (m_cmd == 'h36 && m_params.size() == 1) m_madctl = b;
      if (m_cmd == 'h3A && m_params.size() == 1) m_colmod = b;
      if (m_cmd == 'h2A && m_params.size() == 4) begin
        m_cs = {m_params[0], m_params[1]};
        m_ce = {m_params[2], m_params[3]};
      end
      if (m_cmd == 'h2B && m_params.size() == 4) begin
        m_ps = {m_params[0], m_params[1]};
        m_pe = {m_params[2], m_params[3]};
      end
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sleep"},  sleep_out,  m_sleep);
    check({tag, "_disp"},   disp_on,    m_disp);
    check({tag, "_madctl"}, madctl,     m_madctl);
    check({tag, "_colmod"}, colmod,     m_colmod);
    check({tag, "_cs"},     col_start,  m_cs);
    check({tag, "_ce"},     col_end,    m_ce);
    check({tag, "_ps"},     page_start, m_ps);
    check({tag, "_pe"},     page_end,   m_pe);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_words_left"},  exp_word_q.size(),  0);
    check({tag, "_cmds_left"},   exp_cmd_q.size(),   0);
    check({tag, "_params_left"}, exp_param_q.size(), 0);
    check({tag, "_pixels_left"}, exp_pix_q.size(),   0);
  endtask

  // ---------------- monitor ----------------
  int last_rise_cyc = 0;
  int word_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (word_valid) begin
        check("word_latency", cyc - last_rise_cyc, SYNC + 2);
        word_cyc = cyc;
        check("word_expected", exp_word_q.size() != 0, 1);
        if (exp_word_q.size() != 0) check("word", word_data, exp_word_q.pop_front());
      end
      if (cmd_valid) begin
        check("cmd_latency", cyc - word_cyc, 1);
        check("cmd_idx0", param_idx, 0);
        check("cmd_expected", exp_cmd_q.size() != 0, 1);
        if (exp_cmd_q.size() != 0) check("cmd", cmd_code, exp_cmd_q.pop_front());
      end
      if (param_valid) begin
        check("param_latency", cyc - word_cyc, 1);
        check("param_expected", exp_param_q.size() != 0, 1);
        if (exp_param_q.size() != 0) check("param", {param_idx, param_data}, exp_param_q.pop_front());
      end
      if (pixel_valid) begin
        check("pixel_latency", cyc - word_cyc, 1);
        check("pixel_expected", exp_pix_q.size() != 0, 1);
        if (exp_pix_q.size() != 0) check("pixel", pixel_data, exp_pix_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic spi_bits(input logic d, input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      mosi = b[i];
      dc   = d;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      if (i == 0) last_rise_cyc = cyc;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic d, input logic [7:0] b);
    model_byte(d, b);
    spi_bits(d, b, 8);
    repeat (HALF + 2) @(negedge clk);
  endtask

  task automatic cs_toggle();
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    check_drained(tag);
    @(negedge clk);
    rst = 1'b1;
    sck = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    exp_word_q.delete(); exp_cmd_q.delete(); exp_param_q.delete(); exp_pix_q.delete();
    check_regs({tag, "_rst"});
    check({tag, "_rst_pulses"}, {word_valid, cmd_valid, param_valid, pixel_valid}, 4'b0000);
    check({tag, "_rst_word"},   word_data,  9'h000);
    check({tag, "_rst_cmd"},    cmd_code,   8'h00);
    check({tag, "_rst_pidx"},   param_idx,  4'h0);
    check({tag, "_rst_pdata"},  param_data, 8'h00);
    check({tag, "_rst_pixel"},  pixel_data, 16'h0000);
`ifdef ILI9341_DEC_CHECK_EN
    check({tag, "_rst_seq"},    {seq_err, seq_done}, 2'b00);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] cmd_tab [12];
  logic [7:0] pix_bytes [6];

  initial begin
    cmd_tab = '{8'h01, 8'h10, 8'h11, 8'h28, 8'h29, 8'h2A,
                8'h2B, 8'h2C, 8'h36, 8'h3A, 8'hB1, 8'h00};
    pix_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    model_reset();

    do_reset("init");
    cs_n = 1'b0;
    repeat (4) @(negedge clk);

    // Data with no prior command: word only.
    send(1'b1, 8'h55);
    check_regs("idle");

    // CASET: window updates only on the fourth parameter.
    send(1'b0, 8'h2A);
    send(1'b1, 8'h00); check_regs("caset_p0");
    send(1'b1, 8'h10); check_regs("caset_p1");
    send(1'b1, 8'h00); check_regs("caset_p2");
    check("caset_p2_cs_held", col_start, 16'h0000);
    send(1'b1, 8'hEF); check_regs("caset_p3");
    check("caset_cs", col_start, 16'h0010);
    check("caset_ce", col_end,   16'h00EF);

    // RAMWR: three pixels, then a trailing odd byte dropped by a command.
    send(1'b0, 8'h2C);
    for (int i = 0; i < 6; i++) send(1'b1, pix_bytes[i]);
    check("ramwr_last_pixel", pixel_data, 16'h001F);
    send(1'b1, 8'hAA);
    send(1'b0, 8'h00);
    check_regs("ramwr");

    // Partial byte aborted by CS_n, then MADCTL.
    spi_bits(1'b0, 8'hA5, 5);
    cs_toggle();
    send(1'b0, 8'h36);
    send(1'b1, 8'h48);
    check("madctl_48", madctl, 8'h48);
    check_regs("madctl");

    // D/C is per byte: 0x29 as data of SLPOUT is not DISPON.
    send(1'b0, 8'h11);
    send(1'b1, 8'h29);
    check("slpout_sleep", sleep_out, 1'b1);
    check("slpout_disp",  disp_on,   1'b0);
    send(1'b0, 8'h29);
    check("dispon", disp_on, 1'b1);
    send(1'b0, 8'h01);
    check("swreset_madctl", madctl, 8'h00);
    check("swreset_sleep",  sleep_out, 1'b0);
    check_regs("swreset");

    // rst in the middle of PASET parameter 2.
    send(1'b0, 8'h2B);
    send(1'b1, 8'h00);
    send(1'b1, 8'h00);
    spi_bits(1'b1, 8'h01, 4);
    do_reset("mid_paset");
    send(1'b0, 8'h2B);
    send(1'b1, 8'h00); send(1'b1, 8'h00); send(1'b1, 8'h01); send(1'b1, 8'h3F);
    check_regs("paset_a");
    send(1'b0, 8'h2B);
    send(1'b1, 8'h00); send(1'b1, 8'h20); send(1'b1, 8'h01); send(1'b1, 8'h1F);
    check("paset_ps", page_start, 16'h0020);
    check("paset_pe", page_end,   16'h011F);

    // Parameter index saturation, spanning a CS_n toggle.
    send(1'b0, 8'hB1);
    for (int i = 0; i < 18; i++) begin
      send(1'b1, 8'($urandom_range(0, 255)));
      if (i == 9) cs_toggle();
    end
    check("sat_idx", param_idx, 4'hF);

    // Randomized command traffic.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] c;
      int np;
      c  = cmd_tab[$urandom_range(0, 11)];
      np = (c == 8'h2C) ? $urandom_range(0, 7) : $urandom_range(0, 5);
      send(1'b0, c);
      for (int k = 0; k < np; k++) begin
        send(1'b1, 8'($urandom_range(0, 255)));
        if ($urandom_range(0, 5) == 0) cs_toggle();
      end
      check_regs("rand");
    end

`ifdef ILI9341_DEC_CHECK_EN
    do_reset("seq_good");
    for (int i = 0; i < INI_LEN; i++) send(ini_commands[i][8], ini_commands[i][7:0]);
    check("seq_good_done", seq_done, 1'b1);
    check("seq_good_err",  seq_err,  1'b0);
    do_reset("seq_bad");
    for (int i = 0; i < INI_LEN; i++) begin
      if (i == 5) send(1'b1, 8'h03);
      else send(ini_commands[i][8], ini_commands[i][7:0]);
    end
    check("seq_bad_err",  seq_err,  1'b1);
    check("seq_bad_done", seq_done, 1'b0);
`endif

    repeat (10) @(negedge clk);
    check_drained("end");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
